multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32 datapath.
- Sequences fetch/decode/execute/memory/writeback and drives every datapath strobe.
- Produces the aluop/ctrl_code pair consumed by the ALU control decoder.
- Handshakes with the unified instruction/data memory port via mem_ready.

Parameters:
- RESET_STATE_FETCH, 1, when 1 the FSM leaves reset in FETCH; when 0 it holds in IDLE until the first cycle with rst_n high.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- ir  in  32  instruction register contents; valid from DECODE onward
- mem_ready  in  1  memory done; sampled only in FETCH/MEM_RD/MEM_WR
- aluop  out  2  00=ADD, 01=SUB, 10=decode by ctrl_code
- ctrl_code  out  4  {funct7[5], funct3}; bit3 forced 0 for OP-IMM
- alu_src_a  out  2  00=PC, 01=rs1, 10=old PC
- alu_src_b  out  2  00=rs2, 01=const 4, 10=immediate
- pc_source  out  2  00=ALU result, 01=ALUOut register
- pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write  out  1 each  datapath strobes
- mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
- illegal  out  1  sticky illegal-instruction flag
- retired  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: while rst_n=0 at a rising edge, the next state is FETCH (or IDLE when RESET_STATE_FETCH=0) and illegal=0. Every output is gated to 0 combinationally while rst_n=0. Reset asserted mid-instruction discards the instruction with no partial write.
- Moore outputs are decoded from state only. Unlisted strobes are 0, aluop=00, ctrl_code=0000.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, aluop=00. mem_read is held until mem_ready=1. In the mem_ready=1 cycle, ir_write=1 and pc_write=1 (pc_source=00), then go to DECODE. With mem_ready=0, stay in FETCH with ir_write=pc_write=0.
- DECODE: alu_src_a=10, alu_src_b=10, aluop=00 (branch/jump target into ALUOut). Next state by ir[6:0]:
  - 0000011 -> MEM_ADDR
  - 0100011 -> MEM_ADDR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> ILLEGAL
- Legality checks in DECODE; any failure goes to ILLEGAL:
  - R-type: funct7=0000000 with funct3 in {000,110,111}, or funct7=0100000 with funct3=000.
  - OP-IMM: funct3 in {000,110,111}.
  - Load/store: funct3=010.
  - Branch: funct3=000.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, aluop=00. Next is MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_read=1, iord=1. Wait for mem_ready, then LOAD_WB.
- LOAD_WB: reg_write=1, mem_to_reg=01 -> FETCH.
- MEM_WR: mem_write=1, iord=1. Wait for mem_ready, then FETCH. mem_write is held high for every wait cycle.
- EXEC_R: alu_src_a=01, alu_src_b=00, aluop=10, ctrl_code={ir[30],ir[14:12]} -> ALU_WB.
- EXEC_I: alu_src_a=01, alu_src_b=10, aluop=10, ctrl_code={1'b0,ir[14:12]} -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00 -> FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JAL: reg_write=1, mem_to_reg=10 (PC already holds pc+4), pc_write=1, pc_source=01 -> FETCH.
- ILLEGAL: terminal; illegal=1 and all strobes 0 until reset.
- Cycle counts with mem_ready tied 1:
  - R/I: 4
  - load: 5
  - store: 4
  - branch: 3
  - jal: 3
  - Each mem_ready=0 cycle adds one cycle.
- Retire point: the last state of each instruction (LOAD_WB, MEM_WR exit, ALU_WB, BRANCH, JAL).

Optional Feature:
- Macro RETIRE_CNT_EN.
- When defined: retired is a 32-bit counter. It is cleared by reset, increments by 1 at each retire point, and wraps 0xFFFFFFFF -> 0.
- When undefined: retired is tied to 0 and no counter flops exist.

Decomposition:
- Package RISCV holds:
  - ctrl_state_t enum: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, LOAD_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, ILLEGAL.
  - Opcode localparams.
  - aluop encodings ALUOP_ADD/ALUOP_SUB/ALUOP_FUNC.
  - Mux-select encodings.
- One sub-module, ctrl_legality, is natural: combinational ir -> legal flag, used in DECODE.

Test Plan:
- ir=0x002081B3 (add), mem_ready=1 -> FETCH, DECODE, EXEC_R with aluop=10/ctrl_code=0000, ALU_WB with reg_write=1; 4 cycles; retired +1.
- ir=0x402081B3 (sub) -> EXEC_R ctrl_code=1000. ir=0x40000093 (addi x1,x0,0x400) -> EXEC_I ctrl_code=0000, with bit3 masked.
- ir=0x0080A283 (lw) with mem_ready low 3 cycles in MEM_RD -> mem_read/iord held high 4 cycles; LOAD_WB mem_to_reg=01; 8 cycles total.
- ir=0x0050A623 (sw) -> MEM_WR mem_write=1 for exactly one cycle with mem_ready=1; reg_write never asserted.
- ir=0x00208463 (beq) -> BRANCH aluop=01, pc_write_cond=1, pc_source=01; 3 cycles. ir=0x0000007F -> ILLEGAL, illegal=1 held until rst_n=0.
- rst_n=0 during MEM_WR wait -> all outputs 0 that cycle; FETCH on release; retired=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RV32 control path.
package riscv_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, LOAD_WB, MEM_WR,
    EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, ILLEGAL
  } ctrl_state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // ADD, OR and AND are the only funct3 values this datapath implements.
  function automatic logic funct3_alu_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/ctrl_legality.sv
// Combinational instruction legality check, consulted while in DECODE.
module ctrl_legality
  import riscv_pkg::*;
(
  input  logic [31:0] ir,
  output logic        legal
);

  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       unused_fields;

  assign funct7        = ir[31:25];
  assign funct3        = ir[14:12];
  assign unused_fields = ^{ir[24:15], ir[11:7]};

  always_comb begin
    legal = 1'b0;
    case (ir[6:0])
      OPC_OP:     legal = ((funct7 == 7'b0000000) && funct3_alu_ok(funct3)) ||
                          ((funct7 == 7'b0100000) && (funct3 == 3'b000));
      OPC_OP_IMM: legal = funct3_alu_ok(funct3);
      OPC_LOAD,
      OPC_STORE:  legal = (funct3 == 3'b010);
      OPC_BRANCH: legal = (funct3 == 3'b000);
      OPC_JAL:    legal = 1'b1;
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32 datapath.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module multicycle_control
  import riscv_pkg::*;
#(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [1:0]  aluop,
  output logic [3:0]  ctrl_code,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_source,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        reg_write,
  output logic [1:0]  mem_to_reg,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam ctrl_state_t RESET_ST = RESET_STATE_FETCH ? FETCH : IDLE;

  ctrl_state_t state, next_state;
  logic        legal;

  ctrl_legality u_legality (
    .ir    (ir),
    .legal (legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RESET_ST;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = FETCH;
      FETCH:    if (mem_ready) next_state = DECODE;
      DECODE: begin
        if (!legal) next_state = ILLEGAL;
        else begin
          case (ir[6:0])
            OPC_LOAD, OPC_STORE: next_state = MEM_ADDR;
            OPC_OP:              next_state = EXEC_R;
            OPC_OP_IMM:          next_state = EXEC_I;
            OPC_BRANCH:          next_state = BRANCH;
            OPC_JAL:             next_state = JAL;
            default:             next_state = ILLEGAL;
          endcase
        end
      end
      MEM_ADDR: next_state = (ir[6:0] == OPC_STORE) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) next_state = LOAD_WB;
      LOAD_WB:  next_state = FETCH;
      MEM_WR:   if (mem_ready) next_state = FETCH;
      EXEC_R,
      EXEC_I:   next_state = ALU_WB;
      ALU_WB,
      BRANCH,
      JAL:      next_state = FETCH;
      ILLEGAL:  next_state = ILLEGAL;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    aluop         = ALUOP_ADD;
    ctrl_code     = 4'b0000;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    pc_source     = PC_SRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = WB_ALUOUT;
    illegal       = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
      end
      MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        aluop     = ALUOP_FUNC;
        ctrl_code = {ir[30], ir[14:12]};
      end
      EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        aluop     = ALUOP_FUNC;
        ctrl_code = {1'b0, ir[14:12]};
      end
      ALU_WB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a     = SRC_A_RS1;
        aluop         = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
      end
      JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_PC;
        pc_write   = 1'b1;
        pc_source  = PC_SRC_ALUOUT;
      end
      ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
    // Reset forces every strobe low so an interrupted instruction writes nothing.
    if (!rst_n) begin
      aluop         = 2'b00;
      ctrl_code     = 4'b0000;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 2'b00;
      illegal       = 1'b0;
    end
  end

`ifdef RETIRE_CNT_EN
  logic        retire;
  logic [31:0] retire_cnt;

  always_comb begin
    case (state)
      LOAD_WB, ALU_WB, BRANCH, JAL: retire = 1'b1;
      MEM_WR:                       retire = mem_ready;
      default:                      retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      retire_cnt <= 32'd0;
    else if (retire) retire_cnt <= retire_cnt + 32'd1;
  end

  assign retired = rst_n ? retire_cnt : 32'd0;
`else
  assign retired = 32'd0;
`endif

endmodule
